// File: rtl/hwag_pkg.sv
// Shared types and angle constants for the angle-event scheduler.
// The angle counter wraps from ANGLE_TOP back to 0 once per revolution.
package hwag_pkg;

    localparam int ANGLE_WIDTH = 24;
    localparam int ANGLE_TOP   = 3839;

    typedef enum logic {
        CH_OFF = 1'b0,
        CH_ON  = 1'b1
    } ch_state_t;

    typedef struct packed {
        logic                   en;
        logic [ANGLE_WIDTH-1:0] set;
        logic [ANGLE_WIDTH-1:0] clr;
    } sched_cfg_t;

endpackage

// File: rtl/hwag_sched_channel.sv
// One scheduler channel: active config, OFF/ON state, dwell counter and sticky dwell fault.
// A config being committed this cycle is already the one used for matching.
module hwag_sched_channel
    import hwag_pkg::*;
#(
    parameter int DWELL_MAX = 1280
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_sync,
    input  logic                   i_step,
    input  logic [ANGLE_WIDTH-1:0] i_acnt,
    input  logic                   i_commit,
    input  sched_cfg_t             i_cfg,
    output logic                   o_on,
    output logic                   o_fault
);

    localparam int DW = $clog2(DWELL_MAX + 1);

    sched_cfg_t    r_cfg;
    ch_state_t     r_state;
    logic [DW-1:0] r_dwell;
    logic          r_fault;

    sched_cfg_t    w_cfg;
    logic [DW-1:0] w_dwell_inc;
    logic          w_force_off;
    logic          w_ev;
    logic          w_set_hit;
    logic          w_clr_hit;
    logic          w_trip;

    assign w_cfg       = i_commit ? i_cfg : r_cfg;
    assign w_dwell_inc = r_dwell + 1'b1;
    assign w_force_off = !i_sync || (i_commit && !i_cfg.en);
    assign w_ev        = i_step && !w_force_off;
    assign w_set_hit   = w_cfg.en && (i_acnt == w_cfg.set) && (w_cfg.set != w_cfg.clr);
    assign w_clr_hit   = (i_acnt == w_cfg.clr);
    // Stop angle wins over the dwell limit when both land on the same step.
    assign w_trip      = w_ev && (r_state == CH_ON) && !w_clr_hit && (w_dwell_inc == DW'(DWELL_MAX));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg   <= '0;
            r_state <= CH_OFF;
            r_dwell <= '0;
            r_fault <= 1'b0;
        end else begin
            if (i_commit) begin
                r_cfg <= i_cfg;
            end

            if (w_force_off) begin
                r_state <= CH_OFF;
            end else if (w_ev) begin
                if (r_state == CH_OFF) begin
                    if (w_set_hit) begin
                        r_state <= CH_ON;
                        r_dwell <= '0;
                    end
                end else if (w_clr_hit || w_trip) begin
                    r_state <= CH_OFF;
                end else begin
                    r_dwell <= w_dwell_inc;
                end
            end

            if (w_trip) begin
                r_fault <= 1'b1;
            end else if (i_commit) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign o_on    = (r_state == CH_ON);
    assign o_fault = r_fault;

endmodule

// File: rtl/hwag_event_scheduler.sv
// Multi-channel angle-event scheduler: single pending config slot with handshake and
// range validation, revolution-boundary commit, and loss-of-sync reporting.
module hwag_event_scheduler #(
    parameter int  CH_NUM      = 4,
    parameter int  ANGLE_WIDTH = hwag_pkg::ANGLE_WIDTH,
    parameter int  ANGLE_TOP   = hwag_pkg::ANGLE_TOP,
    parameter int  DWELL_MAX   = 1280,
    localparam int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hwag_start,
    input  logic [ANGLE_WIDTH-1:0] acnt,
    input  logic                   acnt_step,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic                   cfg_en,
    input  logic [ANGLE_WIDTH-1:0] cfg_set,
    input  logic [ANGLE_WIDTH-1:0] cfg_clr,
    output logic                   cfg_err,
    output logic [CH_NUM-1:0]      ch_out,
    output logic [CH_NUM-1:0]      dwell_fault,
    output logic                   sync_lost
);

    import hwag_pkg::sched_cfg_t;

    localparam logic [ANGLE_WIDTH-1:0] L_TOP = ANGLE_WIDTH'(ANGLE_TOP);

    sched_cfg_t        r_pend;
    logic [CH_W-1:0]   r_pend_ch;
    logic              r_pend_vld;
    logic              r_cfg_err;
    logic              r_sync_d;
    logic              r_sync_lost;

    logic              w_accept;
    logic              w_bad;
    logic              w_commit_now;
    logic [CH_NUM-1:0] w_commit;
    logic [CH_NUM-1:0] w_on;

    assign w_accept     = cfg_valid && !r_pend_vld;
    assign w_bad        = (cfg_set > L_TOP) || (cfg_clr > L_TOP) || (int'({1'b0, cfg_ch}) >= CH_NUM);
    // Commit at the revolution boundary, or at once while the angle is not valid.
    assign w_commit_now = r_pend_vld && (!hwag_start || (acnt_step && (acnt == '0)));

    // NOTE: default first so every path assigns w_commit and no latch is inferred.
    always_comb begin
        w_commit = '0;
        if (w_commit_now) begin
            w_commit[r_pend_ch] = 1'b1;
        end
    end

    // NOTE: the pending slot is reset too, so a stale en=1 can never commit after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend      <= '0;
            r_pend_ch   <= '0;
            r_pend_vld  <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_sync_d    <= 1'b0;
            r_sync_lost <= 1'b0;
        end else begin
            r_cfg_err   <= w_accept && w_bad;
            r_sync_d    <= hwag_start;
            r_sync_lost <= r_sync_d && !hwag_start && (|w_on);
            if (w_accept && !w_bad) begin
                r_pend     <= '{en: cfg_en, set: cfg_set, clr: cfg_clr};
                r_pend_ch  <= cfg_ch;
                r_pend_vld <= 1'b1;
            end else if (w_commit_now) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        hwag_sched_channel #(
            .DWELL_MAX(DWELL_MAX)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst),
            .i_sync  (hwag_start),
            .i_step  (acnt_step),
            .i_acnt  (acnt),
            .i_commit(w_commit[g]),
            .i_cfg   (r_pend),
            .o_on    (w_on[g]),
            .o_fault (dwell_fault[g])
        );
    end

    assign cfg_ready = !r_pend_vld;
    assign cfg_err   = r_cfg_err;
    assign sync_lost = r_sync_lost;
    assign ch_out    = w_on;

endmodule

// File: tb/tb_hwag_event_scheduler.sv
// Scoreboard bench: stimulus queues expected output events, a monitor pops and compares
// every cycle in which an output changes or a pulse output is high.
module tb_hwag_event_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hwag_start = 1'b0;
    logic [23:0] acnt = '0;
    logic        acnt_step = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic        cfg_en = 1'b0;
    logic [23:0] cfg_set = '0;
    logic [23:0] cfg_clr = '0;
    logic        cfg_ready;
    logic        cfg_err;
    logic [3:0]  ch_out;
    logic [3:0]  dwell_fault;
    logic        sync_lost;

    hwag_event_scheduler #(
        .CH_NUM(4), .ANGLE_WIDTH(24), .ANGLE_TOP(3839), .DWELL_MAX(1280)
    ) dut (
        .clk(clk), .rst(rst), .hwag_start(hwag_start), .acnt(acnt), .acnt_step(acnt_step),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
        .cfg_set(cfg_set), .cfg_clr(cfg_clr), .cfg_err(cfg_err), .ch_out(ch_out),
        .dwell_fault(dwell_fault), .sync_lost(sync_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ch;
        logic [3:0] df;
        logic       sl;
        logic       err;
        logic       rdy;
        int         tag;
    } ev_t;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic ev(input logic [3:0] ch, input logic [3:0] df, input logic sl,
                      input logic err, input logic rdy, input int tag);
        ev_t e;
        e.ch = ch; e.df = df; e.sl = sl; e.err = err; e.rdy = rdy; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int from, input int to);
        for (int a = from; a <= to; a++) begin
            acnt      = 24'(a);
            acnt_step = 1'b1;
            tick();
        end
        acnt_step = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input logic en, input int set, input int clr);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) begin
            total++;
            bad++;
            $display("FAIL cfg_ready_timeout: got %0b want 1", cfg_ready);
        end
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_en    = en;
        cfg_set   = 24'(set);
        cfg_clr   = 24'(clr);
        tick();
        cfg_valid = 1'b0;
    endtask

    // Monitor: tag each event with the angle the DUT sampled at the preceding edge.
    initial begin : monitor
        logic [3:0] p_ch;
        logic [3:0] p_df;
        logic       p_rdy;
        int         tag;
        ev_t        e;
        p_ch = '0; p_df = '0; p_rdy = 1'b1; tag = 0;
        forever begin
            @(posedge clk);
            tag = int'(acnt);
            @(negedge clk);
            if (!mon_en || !rst) begin
                p_ch = ch_out; p_df = dwell_fault; p_rdy = cfg_ready;
            end else if (ch_out !== p_ch || dwell_fault !== p_df || cfg_ready !== p_rdy ||
                         sync_lost !== 1'b0 || cfg_err !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event@%0d: got ch=%b df=%b sl=%b err=%b rdy=%b want none",
                             tag, ch_out, dwell_fault, sync_lost, cfg_err, cfg_ready);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("event@%0d ch/df/sl/err/rdy", e.tag),
                          {21'd0, ch_out, dwell_fault, sync_lost, cfg_err, cfg_ready},
                          {21'd0, e.ch, e.df, e.sl, e.err, e.rdy});
                    check($sformatf("event@%0d angle", e.tag), tag, e.tag);
                end
                p_ch = ch_out; p_df = dwell_fault; p_rdy = cfg_ready;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (3) tick();
        check("reset ch_out", ch_out, 0);
        check("reset dwell_fault", dwell_fault, 0);
        check("reset sync_lost", sync_lost, 0);
        check("reset cfg_err", cfg_err, 0);
        check("reset cfg_ready", cfg_ready, 1);
        rst = 1'b1;
        tick();
        mon_en = 1'b1;

        // Unsynchronized loads: ready drops for one cycle each (accept N, commit N+1, ready N+2).
        ev(4'b0000, 4'b0000, 0, 0, 0, 0); ev(4'b0000, 4'b0000, 0, 0, 1, 0);
        cfg_write(0, 1'b1, 100, 200);
        ev(4'b0000, 4'b0000, 0, 0, 0, 0); ev(4'b0000, 4'b0000, 0, 0, 1, 0);
        cfg_write(1, 1'b1, 3800, 40);
        ev(4'b0000, 4'b0000, 0, 0, 0, 0); ev(4'b0000, 4'b0000, 0, 0, 1, 0);
        cfg_write(2, 1'b1, 0, 2000);
        ev(4'b0000, 4'b0000, 0, 0, 0, 0); ev(4'b0000, 4'b0000, 0, 0, 1, 0);
        cfg_write(3, 1'b1, 300, 300);
        repeat (2) tick();

        // Revolution 1: ch1 gains sync mid-window and stays off; ch2 trips dwell at 1280.
        hwag_start = 1'b1;
        ev(4'b0100, 4'b0000, 0, 0, 1, 0);
        ev(4'b0101, 4'b0000, 0, 0, 1, 100);
        ev(4'b0100, 4'b0000, 0, 0, 1, 200);
        ev(4'b0000, 4'b0100, 0, 0, 1, 1280);
        ev(4'b0010, 4'b0100, 0, 0, 1, 3800);
        step_to(0, 3839);

        // Revolution 2: wrap window closes at 40; synced write at 1000 held until angle 0.
        ev(4'b0110, 4'b0100, 0, 0, 1, 0);
        ev(4'b0100, 4'b0100, 0, 0, 1, 40);
        ev(4'b0101, 4'b0100, 0, 0, 1, 100);
        ev(4'b0100, 4'b0100, 0, 0, 1, 200);
        step_to(0, 999);
        ev(4'b0100, 4'b0100, 0, 0, 0, 999);
        cfg_write(0, 1'b1, 500, 600);
        ev(4'b0000, 4'b0100, 0, 0, 0, 1280);
        ev(4'b0010, 4'b0100, 0, 0, 0, 3800);
        step_to(1000, 3839);

        // Revolution 3: commit at angle 0, new ch0 window 500..600.
        ev(4'b0110, 4'b0100, 0, 0, 1, 0);
        ev(4'b0100, 4'b0100, 0, 0, 1, 40);
        ev(4'b0101, 4'b0100, 0, 0, 1, 500);
        ev(4'b0100, 4'b0100, 0, 0, 1, 600);
        ev(4'b0000, 4'b0100, 0, 0, 1, 1280);
        ev(4'b0010, 4'b0100, 0, 0, 1, 3800);
        step_to(0, 3839);

        // Revolution 4: drop sync with ch0 and ch2 on, then resync mid-window.
        ev(4'b0110, 4'b0100, 0, 0, 1, 0);
        ev(4'b0100, 4'b0100, 0, 0, 1, 40);
        ev(4'b0101, 4'b0100, 0, 0, 1, 500);
        step_to(0, 550);
        ev(4'b0000, 4'b0100, 1, 0, 1, 550);
        hwag_start = 1'b0;
        repeat (3) tick();
        hwag_start = 1'b1;
        ev(4'b0010, 4'b0100, 0, 0, 1, 3800);
        step_to(551, 3839);

        // Revolution 5: rejected writes leave ch0 closing at its old stop angle 600.
        ev(4'b0110, 4'b0100, 0, 0, 1, 0);
        ev(4'b0100, 4'b0100, 0, 0, 1, 40);
        ev(4'b0101, 4'b0100, 0, 0, 1, 500);
        step_to(0, 550);
        ev(4'b0101, 4'b0100, 0, 1, 1, 550);
        cfg_write(0, 1'b1, 100, 3840);
        tick();
        ev(4'b0101, 4'b0100, 0, 1, 1, 550);
        cfg_write(0, 1'b1, 4000, 200);
        tick();
        ev(4'b0100, 4'b0100, 0, 0, 1, 600);
        step_to(551, 700);
        repeat (2) tick();
        check("queue drained before reset", exp_q.size(), 0);

        // Reset mid-window clears outputs immediately and wipes the active configs.
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async reset ch_out", ch_out, 0);
        check("async reset dwell_fault", dwell_fault, 0);
        check("async reset cfg_ready", cfg_ready, 1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        step_to(0, 400);
        repeat (2) tick();
        check("queue drained at end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hwag_event_scheduler.md
# hwag_event_scheduler

Multi-channel angle-event scheduler driven by the hardware angle generator's angle counter. For each output channel (coil/injector driver) it asserts the output at a programmed start angle and deasserts it at a programmed stop angle; the window may span the 3839→0 wrap. Configuration is double-buffered and committed only at the revolution boundary, or immediately while unsynchronized. A per-channel dwell guard and loss-of-sync handling force outputs off.

## Interface
- CH_NUM, 4, number of output channels (1..16)
- ANGLE_WIDTH, 24, angle bus width
- ANGLE_TOP, 3839, last angle value per revolution (64 steps × 60 teeth − 1)
- DWELL_MAX, 1280, max ON duration in angle steps before forced off

- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- hwag_start  in  1  angle generator synchronized; angle valid only while 1
- acnt  in  ANGLE_WIDTH  current angle, 0..ANGLE_TOP
- acnt_step  in  1  one-cycle strobe: acnt holds a new angle this cycle
- cfg_valid  in  1  config write request
- cfg_ready  out  1  scheduler can accept a config write
- cfg_ch  in  $clog2(CH_NUM)  target channel
- cfg_en  in  1  channel enable
- cfg_set  in  ANGLE_WIDTH  start angle
- cfg_clr  in  ANGLE_WIDTH  stop angle
- cfg_err  out  1  one-cycle pulse: rejected write
- ch_out  out  CH_NUM  channel outputs, registered
- dwell_fault  out  CH_NUM  sticky per-channel dwell-limit flag
- sync_lost  out  1  one-cycle pulse: sync dropped while any channel was ON

## Operation
- Reset values: ch_out=0, dwell_fault=0, sync_lost=0, cfg_err=0, cfg_ready=1; all active and pending configs cleared (en=0).
- Config handshake: a transfer occurs when cfg_valid&cfg_ready. Data go into a single pending slot, and cfg_ready drops.
- Validation at accept: if cfg_set>ANGLE_TOP, cfg_clr>ANGLE_TOP, or cfg_ch≥CH_NUM, pulse cfg_err, discard the write, and keep cfg_ready=1.
- Commit of the pending slot into the channel's active registers happens on either:
  - a cycle with hwag_start=1 and acnt_step=1 and acnt=0; or
  - any cycle with hwag_start=0.
- After commit, cfg_ready returns to 1 on the next cycle.
- A committed config is used for matching at the same step (set=0 fires on that revolution).
- Per-channel FSM states are CH_OFF and CH_ON. Transitions are evaluated only on acnt_step with hwag_start=1:
  - CH_OFF→CH_ON: en=1 and acnt==set and set≠clr.
  - CH_ON→CH_OFF: acnt==clr, or dwell count reaches DWELL_MAX. Dwell case also sets dwell_fault[ch].
- Dwell counter: cleared on entry to CH_ON, incremented per acnt_step while ON.
- Wrap windows (set>clr) need no special case; equality events only.
- Channel gaining sync or enable mid-window stays OFF until its set angle is next seen; there is no partial pulse.
- Commit with en=0 on an ON channel: forced to CH_OFF. Commit with en=1 on an ON channel: stays ON until the new clr matches.
- set==clr: channel never turns on.
- hwag_start 1→0: all channels go to CH_OFF. sync_lost pulses if any was ON.
- dwell_fault[ch] clears only on reset or on a commit to that channel.

## Timing
- Match on step at cycle N → ch_out change visible at N+1.
- hwag_start falls at N → ch_out=0 at N+1, sync_lost high at N+1 only.
- Accept at N → cfg_ready=0 at N+1 (or cfg_err=1 at N+1 on reject).
- Commit at M → cfg_ready=1 at M+1.
- Unsynchronized commit: accept at N, commit at N+1, ready at N+2.
- acnt_step back-to-back every cycle supported. No combinational path from inputs to any output.

## Structure
- Shared package hwag_pkg:
  - angle constants ANGLE_WIDTH and ANGLE_TOP
  - enum ch_state_t {CH_OFF, CH_ON}
  - struct sched_cfg_t {en, set, clr}
- Sub-module hwag_sched_channel: one channel's active config, FSM, dwell counter and fault flag. Instantiated CH_NUM times by generate.
- Top level holds the pending slot, handshake, validation and sync-loss logic.

## Test plan
- Ch0 cfg set=100 clr=200 (unsynced commit), hwag_start=1, step acnt 0..3839 → ch_out[0] high from step-100+1 through step-200+1, exactly 100 steps.
- Ch1 set=3800 clr=40 → ON across wrap for 80 steps; ch_out[1] high while acnt 3800..3839, 0..39.
- Synced write ch0 set=500 clr=600 at acnt=1000 → cfg_ready stays low until acnt=0 step; old window used until then, new window after.
- Ch2 set=0 clr=2000 with DWELL_MAX=1280 → forced off 1280 steps after on, dwell_fault[2]=1 and sticky.
- Drop hwag_start with ch0 ON → ch_out=0 next cycle, sync_lost one-cycle pulse. Resync mid-window → no output until next set angle.
- Write cfg_clr=3840 → cfg_err pulse, cfg_ready stays 1, active config unchanged. Assert rst mid-window → all outputs 0 immediately.
